next_kb_responder: RTL
======================

# next_kb_responder

Keyboard-side endpoint of the NeXT keyboard serial link: it answers poll frames on the keyboard bus the way a physical NeXT keyboard does. It lets a key source inside the FPGA (scan matrix, PS/2 or USB bridge) stand in for the real keyboard behind the sound-box logic. Incoming host frames are deserialised and decoded, key events are buffered in a small FIFO, and one event per poll is serialised back.

## Interface
- `BIT_CLKS`, 1428: clk cycles per bit time (27 MHz / ~18.9 kbit/s); even, ≥ 8.
- `GAP_BITS`, 2: idle bit times between the end of a poll frame and the response start bit.
- `FIFO_DEPTH`, 4: key-event FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock, 27 MHz.
- `reset`  in  1  synchronous, active-high.
- `kb_in`  in  1  serial line from host (host's `to_kb`); asynchronous, idle high.
- `kb_out`  out  1  serial line to host (host's `from_kb`); idle high.
- `key_valid`  in  1  key event offered.
- `key_ready`  out  1  FIFO not full; an event is accepted on a cycle with `key_valid && key_ready`.
- `key_code`  in  7  NeXT keycode.
- `key_up`  in  1  1 = release, 0 = press.
- `key_mods`  in  8  modifier bitmap at event time.
- `leds`  out  2  keyboard LED state from the last LED command.
- `frame_err`  out  1  one-cycle pulse when a received frame is discarded.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `kb_in` passes through a 2-FF synchroniser. All references below to `kb_in` mean the synchronised value.
- Host frame: start bit 0, 9 data bits LSB first (`cmd[8:0]`), stop bit 1.
- Commands:
  - `cmd == 9'h000`: poll; a response is sent.
  - `cmd[8:7] == 2'b11`: LED set; `leds <= cmd[1:0]`, no response.
  - Any other value: ignored, no response, no error.
- Response frame: start bit 0, 17 data bits LSB first, stop bit 1.
  - Data layout: `[6:0]` key_code, `[7]` key_up, `[15:8]` key_mods, `[16]` valid.
  - If the FIFO is empty at response start, the data is 17'h0 (valid = 0).
- State machine:
  - IDLE: a 1→0 transition on `kb_in` moves to RX_START.
  - RX_START: sample at mid-bit. If the sample is 1, treat it as a glitch and return to IDLE without pulsing `frame_err`. If 0, go to RX_DATA.
  - RX_DATA: sample 9 bits, one per BIT_CLKS, then go to RX_STOP.
  - RX_STOP: if the sample is 0, pulse `frame_err` and return to IDLE. Otherwise decode the command: poll goes to GAP; LED set and unknown commands return to IDLE.
  - GAP: wait GAP_BITS·BIT_CLKS cycles, then go to TX.
  - TX: shift out start bit, 17 data bits and stop bit, then return to IDLE.
- `kb_in` is ignored in GAP and TX.
- FIFO:
  - Pop happens on the cycle TX begins; the response shift register loads the head entry and the valid bit on that same cycle.
  - Push and pop on the same cycle are both performed when the FIFO is not full.
  - When full, `key_ready` = 0 and offered events are held off; nothing is dropped.
  - Ordering is strictly first in, first out.
- Reset at any point, including mid-frame: return to IDLE and clear the FIFO.

## Timing
- Reset values: `kb_out`=1, `key_ready`=1, `leds`=0, `frame_err`=0, `busy`=0. These are effective on the cycle after `reset` is sampled high.
- Let t = the cycle the synchronised falling edge is seen.
  - Start bit sampled at t+BIT_CLKS/2.
  - Data bit k (0..8) sampled at t+BIT_CLKS/2+(k+1)·BIT_CLKS.
  - Stop bit sampled at t+BIT_CLKS/2+10·BIT_CLKS.
- `leds` update and the `frame_err` pulse occur the cycle after the stop sample.
- The response start bit is driven on `kb_out` exactly GAP_BITS·BIT_CLKS cycles after the stop sample.
- Each response bit lasts exactly BIT_CLKS cycles, so the full response is 19·BIT_CLKS cycles.
- `kb_out` returns to 1 with the stop bit and stays there until the next response.
- `key_ready` reflects FIFO occupancy with a 1-cycle update after a push or pop.

## Test plan
Benches run with BIT_CLKS=16, GAP_BITS=2, FIFO_DEPTH=4.

- Poll with empty FIFO: send cmd 9'h000. Expect a response with all 17 data bits 0, start bit at stop-sample+32 cycles, total 304 cycles low/high sequence.
- Push {code 7'h25, key_up 0, mods 8'h04}, then poll. Expect data 17'h1_0425. A second poll returns valid 0.
- Push 5 events back to back: `key_ready` drops after the 4th and the 5th is stalled. Four polls return the events in order, and the 5th is accepted as soon as the first pop occurs.
- Send cmd 9'h183: `leds`=2'b11 and `kb_out` stays high. Then send cmd 9'h0A5: no response, `leds` unchanged.
- Frame with stop bit 0: one `frame_err` pulse and no response. A 4-cycle low glitch on `kb_in`: no `frame_err`, state back to IDLE.
- Assert `reset` mid-response: `kb_out`=1 next cycle, FIFO empty, and the next poll returns valid 0.

Source files
------------

// File: rtl/next_kb_responder.sv
// Keyboard-side endpoint of the NeXT keyboard serial link: decodes host poll/LED
// frames and answers each poll with one buffered key event.
module next_kb_responder #(
    parameter int BIT_CLKS   = 1428,
    parameter int GAP_BITS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_in,
    output logic       kb_out,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [6:0] key_code,
    input  logic       key_up,
    input  logic [7:0] key_mods,
    output logic [1:0] leds,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(GAP_BITS * BIT_CLKS + BIT_CLKS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CLKS - 1);
    // GAP ends one cycle early because kb_out is registered on the way into TX.
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_BITS * BIT_CLKS - 2);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] mods;
        logic       up;
        logic [6:0] code;
    } key_evt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP,
        S_GAP,
        S_TX
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic             kb_prev_q, kb_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       rx_sr_q, rx_sr_d;
    logic [17:0]      tx_sr_q, tx_sr_d;
    logic             kb_out_q, kb_out_d;
    logic [1:0]       leds_q, leds_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             key_ready_q, key_ready_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    key_evt_t         fifo_mem [FIFO_DEPTH];
    key_evt_t         wr_evt, head_evt;
    logic             kb_s, push, pop;

    assign kb_s     = sync_q[1];
    assign wr_evt   = '{mods: key_mods, up: key_up, code: key_code};
    assign head_evt = fifo_mem[rd_ptr_q];
    assign push     = key_valid && key_ready_q;

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], kb_in};
        kb_prev_d   = kb_s;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        kb_out_d    = kb_out_q;
        leds_d      = leds_q;
        frame_err_d = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (kb_prev_q && !kb_s) state_d = S_RX_START;
            end
            S_RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = kb_s ? S_IDLE : S_RX_DATA;
                end
            end
            S_RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    rx_sr_d   = {kb_s, rx_sr_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd8) state_d = S_RX_STOP;
                end
            end
            S_RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!kb_s)                     frame_err_d = 1'b1;
                    else if (rx_sr_q == 9'h000)    state_d     = S_GAP;
                    else if (rx_sr_q[8:7] == 2'b11) leds_d     = rx_sr_q[1:0];
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_TX;
                    kb_out_d  = 1'b0;
                    pop       = (occ_q != '0);
                    tx_sr_d   = pop ? {1'b1, 1'b1, head_evt} : {1'b1, 17'h0};
                end
            end
            S_TX: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd18) begin
                        state_d = S_IDLE;
                    end else begin
                        kb_out_d  = tx_sr_q[0];
                        tx_sr_d   = {1'b1, tx_sr_q[17:1]};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (pop && !push) occ_d = occ_q - OCC_W'(1);
        key_ready_d = (occ_d != OCC_FULL);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            kb_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '1;
            kb_out_q    <= 1'b1;
            leds_q      <= 2'b00;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            kb_prev_q   <= kb_prev_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            kb_out_q    <= kb_out_d;
            leds_q      <= leds_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            key_ready_q <= key_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_evt;
    end

    assign kb_out    = kb_out_q;
    assign key_ready = key_ready_q;
    assign leds      = leds_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
